// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with internal baud divider.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_enb,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    logic [BW-1:0]        baud;
    logic                 baud_end;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tx_nxt;

`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`else
    logic                 unused_parity;
    assign unused_parity = parity_odd;
`endif

    // full is a register, so a write is judged against the pre-pop state
    assign push       = wr_enb && !full;
    assign fifo_empty = (count == '0);
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign baud_end   = (baud == BAUD_LAST);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // FIFO pointers, occupancy and the registered full/overflow flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full     <= (count_nxt == DEPTH_C);
            overflow <= wr_enb && full;
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // frame sequencing: advance one state per completed bit period
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = S_START;
            end
            S_START: begin
                if (baud_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (baud_end && bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end && bit_cnt == STOP_LAST) begin
                    state_nxt = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // pop and the next line level; STOP chains straight into START
    always_comb begin
        pop    = 1'b0;
        tx_nxt = tx;
        unique case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    tx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) tx_nxt = shreg[0];
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt = par_bit;
`else
                        tx_nxt = 1'b1;
`endif
                    end else begin
                        tx_nxt = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) tx_nxt = 1'b1;
            end
`endif
            S_STOP: begin
                tx_nxt = 1'b1;
                if (baud_end && bit_cnt == STOP_LAST && !fifo_empty) begin
                    pop    = 1'b1;
                    tx_nxt = 1'b0;
                end
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    // baud divider, bit counter, shift register and the tx flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            tx <= tx_nxt;
            if (pop) begin
                baud  <= '0;
                shreg <= mem[rd_ptr];
            end else begin
                if (state != S_IDLE) baud <= baud_end ? '0 : baud + 1'b1;
                if (state == S_DATA && baud_end) shreg <= shreg >> 1;
            end
            if (pop || state != state_nxt) bit_cnt <= '0;
            else if (baud_end)             bit_cnt <= bit_cnt + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // parity of the popped word, frozen for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par_bit <= 1'b0;
        else if (pop) par_bit <= (^mem[rd_ptr]) ^ parity_odd;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table, corner sequences and a random run
// checked against a frame-level reference model of the transmitter.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB   = 1 + DW + P + SB;
    localparam int FLEN = NB * CPB;
    localparam int NB_B = 1 + 5 + P + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_enb = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          parity_odd = 1'b0;
    logic          tx, busy, full, overflow;

    logic          wr_b = 1'b0;
    logic [4:0]    data_b = '0;
    logic          tx_b, busy_b, full_b, ovf_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       podd;
        logic       par;
    } vec_t;
    vec_t vecs[5];

    uart_tx_fifo #(
        .DATA_BITS(DW), .CLKS_PER_BIT(CPB),
        .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_enb(wr_enb),
        .data_in(data_in), .parity_odd(parity_odd),
        .tx(tx), .busy(busy), .full(full), .overflow(overflow)
    );

    uart_tx_fifo #(
        .DATA_BITS(5), .CLKS_PER_BIT(CPB),
        .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_enb(wr_b),
        .data_in(data_b), .parity_odd(parity_odd),
        .tx(tx_b), .busy(busy_b), .full(full_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(vec_t v, int b);
        if (b == 0)  return 1'b0;
        if (b <= DW) return v.data[b-1];
        if (P == 1 && b == DW + 1) return v.par;
        return 1'b1;
    endfunction

    // reference model: queue of accepted words plus the frame on the wire
    logic [DW-1:0] mq[$];
    bit            m_act = 1'b0;
    bit            m_full = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_push;
    int            m_pos = 0;
    int            m_nb = 0;
    bit            m_bits[16];
    logic [DW-1:0] m_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_act  = 1'b0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            m_pos  = 0;
        end else begin
            m_push = wr_enb && !m_full;
            m_ovf  = wr_enb && m_full;
            if (m_act) begin
                m_pos++;
                if (m_pos == m_nb * CPB) m_act = 1'b0;
            end
            if (!m_act && mq.size() > 0) begin
                m_d = mq.pop_front();
                m_bits[0] = 1'b0;
                for (int i = 0; i < DW; i++) m_bits[1+i] = m_d[i];
                m_nb = 1 + DW;
`ifdef UART_TX_PARITY_EN
                m_bits[m_nb] = (^m_d) ^ parity_odd;
                m_nb++;
`endif
                for (int s = 0; s < SB; s++) begin
                    m_bits[m_nb] = 1'b1;
                    m_nb++;
                end
                m_act = 1'b1;
                m_pos = 0;
            end
            if (m_push) mq.push_back(data_in);
            m_full = (mq.size() == DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx", tx, m_act ? m_bits[m_pos/CPB] : 1'b1);
            check("model_busy", busy, m_act || mq.size() > 0);
            check("model_full", full, m_full);
            check("model_ovf", overflow, m_ovf);
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1};
        vecs[4] = '{8'h01, 1'b0, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            wr_enb     = 1'b1;
            data_in    = vecs[v].data;
            parity_odd = vecs[v].podd;
            @(negedge clk);
            wr_enb = 1'b0;
            check("tbl_busy_rise", busy, 1);
            check("tbl_tx_pre", tx, 1);
            @(negedge clk);
            data_in    = ~vecs[v].data;
            parity_odd = ~vecs[v].podd;
            for (int k = 0; k < FLEN; k++) begin
                if (k > 0) @(negedge clk);
                check("tbl_tx", tx, exp_bit(vecs[v], k / CPB));
                check("tbl_busy", busy, 1);
            end
            @(negedge clk);
            check("tbl_busy_fall", busy, 0);
            check("tbl_tx_idle", tx, 1);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            wr_enb     = 1'b1;
            data_in    = 8'($urandom);
            parity_odd = 1'($urandom);
            @(negedge clk);
            if (i == 0) t0 = cyc;
            if (i == 3) check("full_early", full, 0);
            if (i == 4) begin
                check("full_set", full, 1);
                check("ovf_pre", overflow, 0);
            end
        end
        wr_enb = 1'b0;
        check("ovf_pulse", overflow, 1);
        check("full_hold", full, 1);
        @(negedge clk);
        check("ovf_clear", overflow, 0);
        for (int w = 0; w < 6 * FLEN && busy; w++) @(negedge clk);
        check("five_busy_fall", busy, 0);
        check("five_frames_len", cyc - t0, 1 + 5 * FLEN);

        for (int i = 0; i < 1500; i++) begin
            wr_enb     = ($urandom_range(0, 5) == 0);
            data_in    = 8'($urandom);
            parity_odd = 1'($urandom);
            @(negedge clk);
        end
        wr_enb = 1'b0;
        for (int w = 0; w < (DEPTH + 2) * FLEN && busy; w++) @(negedge clk);
        check("rand_drain", busy, 0);

        for (int i = 0; i < 3; i++) begin
            wr_enb  = 1'b1;
            data_in = 8'h00;
            @(negedge clk);
        end
        wr_enb = 1'b0;
        repeat (CPB + 2) @(negedge clk);
        check("pre_rst_tx", tx, 0);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3 * FLEN; k++) begin
            @(negedge clk);
            check("post_rst_tx", tx, 1);
            check("post_rst_busy", busy, 0);
        end
        wr_enb  = 1'b1;
        data_in = 8'h3C;
        @(negedge clk);
        wr_enb = 1'b0;
        for (int w = 0; w < 2 * FLEN && busy; w++) @(negedge clk);
        check("post_rst_frame", busy, 0);

        wr_b       = 1'b1;
        data_b     = 5'h1F;
        parity_odd = 1'b0;
        @(negedge clk);
        wr_b = 1'b0;
        check("b_busy_rise", busy_b, 1);
        check("b_tx_pre", tx_b, 1);
        for (int k = 0; k < NB_B * CPB; k++) begin
            @(negedge clk);
            check("b_tx", tx_b, (k < CPB) ? 0 : 1);
            check("b_busy", busy_b, 1);
        end
        @(negedge clk);
        check("b_busy_fall", busy_b, 0);
        check("b_tx_idle", tx_b, 1);
        check("b_full", full_b, 0);
        check("b_ovf", ovf_b, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal baud-rate divider, a transmit FIFO, configurable frame format and optional parity. It sits between the bus-side write port and the serial `tx` pin. It accepts back-to-back byte writes without waiting for `busy`, and it drives frames continuously while the FIFO holds data.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal ≥2.
- `STOP_BITS`, 1: stop bits per frame; legal 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_enb` in 1: write strobe; pushes `data_in` when `full`=0.
- `data_in` in DATA_BITS: word to transmit.
- `parity_odd` in 1: parity select; 1 = odd, 0 = even; sampled at frame launch.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `full` out 1: FIFO holds FIFO_DEPTH entries.
- `overflow` out 1: one-cycle pulse when `wr_enb`=1 is dropped because `full`=1.

## Operation
- Reset (async assert): `tx`=1, `busy`=0, `full`=0, `overflow`=0. FIFO is emptied, pointers and count are 0, state is IDLE, and the bit and baud counters are 0. Reset mid-frame aborts the frame, drives `tx` high immediately and discards queued data.
- FIFO: circular buffer with a count of width clog2(FIFO_DEPTH)+1.
  - `full` is evaluated before any same-cycle pop. A write while `full`=1 is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, latch `parity_odd`, clear the baud counter, drive `tx`=0 and go to START.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: data is sent LSB first. Each bit is held CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if parity is compiled in, otherwise go to STOP.
  - PARITY: drive XOR of the data bits, XORed with the latched `parity_odd`. Hold one bit period, then go to STOP.
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and re-enter START directly (no idle gap). Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
- `tx` is registered; no combinational path from any input to `tx`.

## Timing
- Write accepted at edge N into an empty FIFO while IDLE: pop at edge N+1, and `tx` falls after edge N+1.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle.
- `busy` rises the cycle after the first accepted write. It falls the cycle after the final stop period ends with the FIFO empty.
- `full` and `overflow` are registered and update the cycle after the causing edge.
- `data_in` and `parity_odd` changes after acceptance or launch do not affect the frame in flight.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and its parity bit are inserted after the data bits, and `parity_odd` selects odd or even.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state, the frame goes DATA→STOP, and `parity_odd` is ignored (the port remains).

## Test plan
- Reset, then DATA_BITS=8, CLKS_PER_BIT=4, no parity; write 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles). `busy` is high throughout and low afterwards.
- Parity compiled in; write 0xA5 with `parity_odd`=0 → parity bit 0. With `parity_odd`=1 → parity bit 1. Frame length is 44 cycles.
- FIFO_DEPTH=4; six consecutive writes while the first frame is in flight → `full` is asserted after the 5th accepted write, `overflow` pulses once for the 6th, and exactly 5 frames are sent back-to-back with no idle gap.
- STOP_BITS=2, DATA_BITS=5; write 0x1F → start bit 0, five 1s, stop high for 8 cycles, 32-cycle frame.
- Assert `rst_n`=0 mid-DATA with 2 queued entries → `tx`=1 immediately, `busy`=0, `full`=0, and nothing is transmitted after release until a new write.
